// File: rtl/mux_8to1_pkg.sv
// rtl/mux_8to1_pkg.sv - shared constants and helpers for the N-to-1 selector
package mux_8to1_pkg;

   localparam int MUX_N = 8;
   localparam int MUX_W = 1;

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/mux_2to1.sv
// rtl/mux_2to1.sv - W-bit two-input selector, one node of the select tree
module mux_2to1 #(
   parameter int W = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         s,
   output logic [W-1:0] y
);

   // Ternary keeps an X select visible on differing inputs
   assign y = s ? b : a;

endmodule

// File: rtl/mux_8to1.sv
// rtl/mux_8to1.sv - N-to-1 word selector with combinational and registered outputs
module mux_8to1
   import mux_8to1_pkg::*;
#(
   parameter int N     = MUX_N,
   parameter int W     = MUX_W,
   parameter int SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N*W-1:0]   x,
   input  logic [SEL_W-1:0] a,
   input  logic             en,
   output logic [W-1:0]     y,
   output logic [W-1:0]     y_q
);

   generate
      if (!is_pow2(N)) begin : g_bad_n
         $error("mux_8to1: N must be a power of two and at least 2");
      end
   endgenerate

   // Heap-ordered tree: node i has children 2i+1 and 2i+2, leaves N-1.. hold slots 0..
   logic [2*N-2:0][W-1:0] tree;

   genvar k;
   generate
      for (k = 0; k < N; k++) begin : g_leaf
         assign tree[N-1+k] = x[k*W +: W];
      end

      for (k = 0; k < N-1; k++) begin : g_node
         localparam int DEPTH = $clog2(k + 2) - 1;
         mux_2to1 #(.W(W)) u_mux (
            .a (tree[2*k+1]),
            .b (tree[2*k+2]),
            .s (a[SEL_W-1-DEPTH]),
            .y (tree[k])
         );
      end
   endgenerate

   assign y = tree[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= '0;
      end else if (en) begin
         y_q <= y;
      end
   end

endmodule

// File: tb/tb_mux_8to1.sv
// tb/tb_mux_8to1.sv - directed scoreboard bench for mux_8to1
module tb_mux_8to1;

   logic        clk;
   logic        clk_run;
   logic        rst_n;
   logic [7:0]  x;
   logic [2:0]  a;
   logic        en;
   logic [0:0]  y;
   logic [0:0]  y_q;

   logic [31:0] xw;
   logic [1:0]  aw;
   logic [7:0]  yw;
   logic [7:0]  yw_q;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];

   mux_8to1 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x),
      .a     (a),
      .en    (en),
      .y     (y),
      .y_q   (y_q)
   );

   mux_8to1 #(.N(4), .W(8)) dut_wide (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (xw),
      .a     (aw),
      .en    (en),
      .y     (yw),
      .y_q   (yw_q)
   );

   initial clk = 1'b0;
   always #5 if (clk_run) clk = ~clk;

   task automatic expect_val(input logic [7:0] v);
      sb.push_back(v);
   endtask

   task automatic check(input string tag, input logic [7:0] obs);
      logic [7:0] exp;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard empty obs=%h", tag, obs);
      end else begin
         exp = sb.pop_front();
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
         end
      end
   endtask

   initial begin
      logic [7:0] sweep_a[4];
      logic [7:0] sweep_e[4];
      clk_run = 1'b0;
      rst_n   = 1'b1;
      en      = 1'b0;
      x       = 8'h00;
      a       = 3'd0;
      xw      = 32'hDDCC_BBAA;
      aw      = 2'd0;

      // Power-up and asynchronous reset without any clock edge
      #1;
      expect_val(8'h00); check("pwr_y", {7'b0, y});
      rst_n = 1'b0;
      #1;
      expect_val(8'h00); check("async_rst_yq", {7'b0, y_q});
      expect_val(8'h00); check("async_rst_ywq", yw_q);

      // Alternating pattern sweep, still unclocked
      sweep_a = '{8'd2, 8'd7, 8'd0, 8'd3};
      sweep_e = '{8'd1, 8'd0, 8'd1, 8'd0};
      x = 8'b0101_0101;
      for (int i = 0; i < 4; i++) begin
         a = sweep_a[i][2:0];
         expect_val(sweep_e[i]);
         #1;
         check("sweep_y", {7'b0, y});
      end

      // Exhaustive combinational selection
      for (int xv = 0; xv < 256; xv++) begin
         for (int av = 0; av < 8; av++) begin
            x = xv[7:0];
            a = av[2:0];
            expect_val(8'((xv >> av) & 1));
            #1;
            check("exh_y", {7'b0, y});
         end
      end

      // y keeps tracking while reset is held
      x = 8'h08; a = 3'd3;
      expect_val(8'h01);
      #1; check("rst_y_track", {7'b0, y});

      // Reset held across enabled edges keeps y_q at zero
      clk_run = 1'b1;
      en = 1'b1;
      @(posedge clk); #1;
      expect_val(8'h00); check("rst_hold_yq", {7'b0, y_q});

      // Registered path
      @(negedge clk);
      rst_n = 1'b1;
      x = 8'h80; a = 3'd7; en = 1'b1;
      @(posedge clk); #1;
      expect_val(8'h01); check("load_yq", {7'b0, y_q});
      @(negedge clk);
      en = 1'b0; a = 3'd0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         expect_val(8'h01); check("hold_yq", {7'b0, y_q});
         expect_val(8'h00); check("hold_y", {7'b0, y});
      end

      // Reset coincident with an enabled edge wins
      @(negedge clk);
      a = 3'd7; en = 1'b1;
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      expect_val(8'h00); check("rst_prio_yq", {7'b0, y_q});
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      expect_val(8'h01); check("post_rst_load", {7'b0, y_q});

      // Enabled load of a zero after a one
      @(negedge clk);
      a = 3'd0;
      @(posedge clk); #1;
      expect_val(8'h00); check("load_zero", {7'b0, y_q});

      // Wide configuration: four byte-wide slots
      for (int i = 0; i < 4; i++) begin
         aw = i[1:0];
         expect_val(8'(32'hDDCC_BBAA >> (8 * i)));
         #1;
         check("wide_y", yw);
      end
      @(negedge clk);
      aw = 2'd2;
      @(posedge clk); #1;
      expect_val(8'hCC); check("wide_yq", yw_q);

      clk_run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_8to1.md
# mux_8to1

Parameterised N-to-1 bit/word selector with a combinational output and an optional registered copy. The default configuration selects one bit of an 8-bit vector `x` using a 3-bit index `a`. It sits in datapath glue wherever a narrow field must be picked from a packed bus, for example status-bit selection or a lane select. The combinational path `y` is the primary output; `y_q` serves consumers that need a flop boundary.

## Interface
- `N`, default 8: number of inputs; must be a power of two, ≥2.
- `W`, default 1: width of each input slot and of the outputs.
- `SEL_W`, default $clog2(N) = 3: width of the select index; derived, not overridden.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `x`  in  N*W: packed inputs; slot k is `x[k*W +: W]`, so slot 0 is at the LSBs.
- `a`  in  SEL_W: select index.
- `en`  in  1: load enable for `y_q`.
- `y`  out  W: combinational selected slot.
- `y_q`  out  W: registered copy of `y`.

## Operation
- `y = x[a*W +: W]` at all times, purely combinational. `y` does not depend on `clk`, `rst_n` or `en`.
- Every value of `a` from 0 to N-1 is legal. Because N is a power of two, no index is out of range.
- X/Z on `a` must not be masked in simulation: `y` goes X.
- `y_q` is updated with `y` on each rising `clk` edge when `en` = 1. When `en` = 0, `y_q` holds its value.
- Reset behaviour:
  - `rst_n` = 0 forces `y_q` to all zeros immediately, without waiting for a clock.
  - While reset is held, `y_q` stays 0 regardless of `en`.
  - The first load can occur on the first rising edge after `rst_n` deasserts.
- Reset has no effect on `y`.
- Elaboration must fail (assertion or `$error`) if N is not a power of two or N < 2.

## Timing
- `y`: zero-cycle latency. Valid one combinational delay after any change of `x` or `a`.
- `y_q`: one-cycle latency. It equals the `y` value sampled at the enabling edge.
- If `a` or `x` changes in the same cycle as an enabled edge, `y_q` takes the pre-edge `y`.
- Simultaneous reset and enabled edge: reset wins, and `y_q` = 0.
- Reset mid-stream: `y_q` clears asynchronously; `y` continues to track its inputs.

## Structure
- The shared package holds:
  - a `clog2` helper, or reliance on `$clog2`;
  - the default constants `MUX_N` = 8 and `MUX_W` = 1.
- The natural sub-module is `mux_2to1` (W-bit: `s ? b : a`). The top builds a log2(N)-level tree of these, with level j driven by `a[j]`, and then adds the `y_q` register.
- A flat indexed-part-select implementation is equally acceptable if it gives identical results.

## Test plan
1. Power-up: `x` = 0x00, `a` = 0 → `y` = 0. Assert `rst_n` = 0 → `y_q` = 0 at once, with no clock edge.
2. `x` = 8'b0101_0101, sweep `a` = 2, 7, 0, 3 with 1 ns between steps → `y` = 1, 0, 1, 0, with no clock applied.
3. Exhaustive: for each of the 256 values of `x` and each `a` in 0..7 → `y` == `x[a]`.
4. Registered path: `en` = 1, `x` = 0x80, `a` = 7 → after one edge `y_q` = 1. Set `en` = 0 and `a` = 0 → `y_q` stays 1 across 3 edges while `y` = 0.
5. Reset priority: with `y_q` = 1, assert `rst_n` low coincident with an enabled edge → `y_q` = 0. Release → the next enabled edge loads the current `y`.
6. Wide config `N` = 4, `W` = 8, `x` = 0xDDCCBBAA → `a` = 0..3 gives `y` = 0xAA, 0xBB, 0xCC, 0xDD.
